// File: rtl/add_seq_ctrl_pkg.sv
// Shared types and helpers for the nibble-serial add/subtract sequencer.
// Holds the nibble width, the FSM state type and the signed-overflow rule.
package add_seq_ctrl_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} add_seq_state_t;

  // Overflow when both operands share a sign and the result's sign differs.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/add_seq_ctrl.sv
// Sequencer that runs a DATA_W-bit add/subtract through one external 4-bit adder,
// one nibble per cycle LSB first, and returns the assembled result over valid/ready.
module add_seq_ctrl
  import add_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              req_sub,
  input  logic              req_cin,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_sum,
  output logic              rsp_cout,
  output logic              rsp_ovf,
  output logic [3:0]        add_a,
  output logic [3:0]        add_b,
  output logic              add_cin,
  input  logic [3:0]        add_sum,
  input  logic              add_cout,
  output logic              busy
);

  localparam int NIB   = DATA_W / NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);
  localparam int MSB   = DATA_W - 1;

  generate
    if ((DATA_W % NIB_W) != 0 || DATA_W < NIB_W) begin : g_bad_width
      $error("add_seq_ctrl: DATA_W must be a positive multiple of 4");
    end
  endgenerate

  add_seq_state_t    state, next_state;
  logic [IDX_W-1:0]  idx;
  logic              carry;
  logic [DATA_W-1:0] opa, opb, res;

  // Subtraction is folded into the capture: B is stored inverted and carry starts at 1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (req_valid) begin
            opa   <= req_a;
            opb   <= req_sub ? ~req_b : req_b;
            carry <= req_sub ? 1'b1 : req_cin;
            idx   <= '0;
          end
        end
        RUN: begin
          res[idx*NIB_W +: NIB_W] <= add_sum;
          carry <= add_cout;
          if (idx != LAST_IDX) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_sum    = '0;
    rsp_cout   = 1'b0;
    rsp_ovf    = 1'b0;
    add_a      = '0;
    add_b      = '0;
    add_cin    = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = reset;
        if (req_valid) next_state = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        add_a   = opa[idx*NIB_W +: NIB_W];
        add_b   = opb[idx*NIB_W +: NIB_W];
        add_cin = carry;
        if (idx == LAST_IDX) next_state = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        rsp_sum   = res;
        rsp_cout  = carry;
        rsp_ovf   = signed_ovf(opa[MSB], opb[MSB], res[MSB]);
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Scoreboard bench for add_seq_ctrl: a behavioural 4-bit adder closes the loop and
// full-width expected results are queued at each request handshake.
module tb_add_seq_ctrl;

  localparam int DATA_W = 16;
  localparam int NIB    = DATA_W / 4;

  typedef struct {
    logic [DATA_W-1:0] sum;
    logic              cout;
    logic              ovf;
  } exp_t;

  logic              clock;
  logic              reset;
  logic              req_valid, req_ready, req_sub, req_cin;
  logic [DATA_W-1:0] req_a, req_b;
  logic              rsp_valid, rsp_ready, rsp_cout, rsp_ovf;
  logic [DATA_W-1:0] rsp_sum;
  logic [3:0]        add_a, add_b, add_sum;
  logic              add_cin, add_cout, busy;

  exp_t sb[$];
  logic [3:0] exp_na[NIB];
  logic [3:0] exp_nb[NIB];
  logic       exp_nc[NIB];
  int total_count;
  int bad_count;

  add_seq_ctrl #(.DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .busy(busy)
  );

  assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_count++;
    if (observed !== expected) begin
      bad_count++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // Waits (bounded) for req_ready, handshakes on the next edge and queues the expected result.
  task automatic apply_stimulus(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                input logic sub, input logic cin);
    logic [DATA_W-1:0] bb;
    logic [DATA_W:0]   full;
    logic [4:0]        t;
    logic              c;
    exp_t              e;
    int                n;
    req_a = a; req_b = b; req_sub = sub; req_cin = cin; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check_output("req_ready_wait", 32'(n < 20), 32'd1);
    bb   = sub ? ~b : b;
    c    = sub ? 1'b1 : cin;
    full = {1'b0, a} + {1'b0, bb} + (DATA_W+1)'(c);
    e.sum  = full[DATA_W-1:0];
    e.cout = full[DATA_W];
    e.ovf  = sub ? ((a[DATA_W-1] != b[DATA_W-1]) && (e.sum[DATA_W-1] != a[DATA_W-1]))
                 : ((a[DATA_W-1] == b[DATA_W-1]) && (e.sum[DATA_W-1] != a[DATA_W-1]));
    for (int k = 0; k < NIB; k++) begin
      exp_na[k] = a[k*4 +: 4];
      exp_nb[k] = bb[k*4 +: 4];
      exp_nc[k] = c;
      t = 5'(exp_na[k]) + 5'(exp_nb[k]) + 5'(c);
      c = t[4];
    end
    @(posedge clock);
    sb.push_back(e);
    #1 req_valid = 1'b0;
  endtask

  // Follows the nibble sequence, checks latency and result, optionally stalls rsp_ready.
  task automatic collect_response(input int hold);
    exp_t e;
    int   n;
    for (int k = 0; k < NIB; k++) begin
      @(negedge clock);
      check_output($sformatf("add_a[%0d]", k), 32'(add_a), 32'(exp_na[k]));
      check_output($sformatf("add_b[%0d]", k), 32'(add_b), 32'(exp_nb[k]));
      check_output($sformatf("add_cin[%0d]", k), 32'(add_cin), 32'(exp_nc[k]));
      check_output("early_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    @(negedge clock);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    check_output("latency_extra", 32'(n), 32'd0);
    if (sb.size() == 0) begin
      check_output("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check_output("rsp_sum", 32'(rsp_sum), 32'(e.sum));
    check_output("rsp_cout", 32'(rsp_cout), 32'(e.cout));
    check_output("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
    check_output("done_add_a", 32'(add_a), 32'd0);
    for (int h = 0; h < hold; h++) begin
      req_a = 16'hAAAA; req_b = 16'h5555; req_sub = 1'b0; req_cin = 1'b0; req_valid = 1'b1;
      @(negedge clock);
      check_output("hold_valid", 32'(rsp_valid), 32'd1);
      check_output("hold_sum", 32'(rsp_sum), 32'(e.sum));
      check_output("hold_cout", 32'(rsp_cout), 32'(e.cout));
      check_output("hold_ovf", 32'(rsp_ovf), 32'(e.ovf));
      check_output("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    check_output("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("post_req_ready", 32'(req_ready), 32'd1);
    check_output("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    total_count = 0;
    bad_count   = 0;
    reset = 1'b0;
    req_valid = 1'b0; req_a = '0; req_b = '0; req_sub = 1'b0; req_cin = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clock);
    check_output("rst_req_ready", 32'(req_ready), 32'd0);
    check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_add_a", 32'(add_a), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check_output("idle_req_ready", 32'(req_ready), 32'd1);

    apply_stimulus(16'h1234, 16'h4321, 1'b0, 1'b0); collect_response(0);
    apply_stimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0); collect_response(0);
    apply_stimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0); collect_response(0);
    apply_stimulus(16'h8000, 16'h0001, 1'b1, 1'b0); collect_response(0);
    apply_stimulus(16'h0005, 16'h0007, 1'b1, 1'b1); collect_response(0);
    apply_stimulus(16'h0F0F, 16'h00F1, 1'b0, 1'b1); collect_response(5);
    apply_stimulus(16'h2468, 16'h1357, 1'b1, 1'b0); collect_response(0);

    // Abort mid-RUN at idx 2: outputs must clear asynchronously, between edges.
    apply_stimulus(16'hABCD, 16'h1111, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    check_output("pre_abort_add_a", 32'(add_a), 32'(exp_na[2]));
    #2 reset = 1'b0;
    #1;
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_req_ready", 32'(req_ready), 32'd0);
    check_output("abort_add_a", 32'(add_a), 32'd0);
    check_output("abort_add_b", 32'(add_b), 32'd0);
    check_output("abort_add_cin", 32'(add_cin), 32'd0);
    check_output("abort_rsp_sum", 32'(rsp_sum), 32'd0);
    if (sb.size() > 0) void'(sb.pop_back());
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check_output("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    reset = 1'b1;
    #1 check_output("release_req_ready", 32'(req_ready), 32'd1);
    @(negedge clock);
    apply_stimulus(16'h0001, 16'h0001, 1'b0, 1'b0); collect_response(0);

    $display("test done: total=%0d bad=%0d", total_count, bad_count);
    $finish;
  end

endmodule

// File: doc/add_seq_ctrl.md
Name: add_seq_ctrl

Overview:
Sequencer that performs DATA_W-bit add/subtract by time-multiplexing one external 4-bit ripple adder. The adder's outputs are sum[3:0] and cout. The block accepts one operation over a valid/ready request port and drives the adder one nibble per cycle, LSB nibble first, chaining the carry. It assembles the full result and returns it over a valid/ready response port. It sits between the stimulus/command side and the 4-bit adder datapath.

Parameters:
DATA_W, 16, operand/result width. Must be a multiple of 4 and at least 4 (elaboration-time assertion).
NIB, DATA_W/4, derived nibble count. Localparam, not overridable.

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
req_valid  input  1  request valid
req_ready  output  1  request ready (high only in IDLE)
req_a  input  DATA_W  operand A
req_b  input  DATA_W  operand B
req_sub  input  1  1 = A-B, 0 = A+B
req_cin  input  1  carry-in for add; ignored when req_sub=1
rsp_valid  output  1  result valid
rsp_ready  input  1  result accepted
rsp_sum  output  DATA_W  result
rsp_cout  output  1  final carry-out (for subtract, 0 = borrow)
rsp_ovf  output  1  two's-complement overflow
add_a  output  4  adder operand A nibble
add_b  output  4  adder operand B nibble (already inverted for subtract)
add_cin  output  1  adder carry-in
add_sum  input  4  adder sum (combinational from add_a/add_b/add_cin)
add_cout  input  1  adder carry-out
busy  output  1  high in RUN or DONE

Behaviour:
- Reset is asynchronous, active-low, with synchronous release. While asserted:
  - state=IDLE, idx=0, carry=0, internal regs=0.
  - rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0, busy=0.
  - add_a=0, add_b=0, add_cin=0. req_ready=0 during reset, 1 from the first cycle after release.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, at the clock edge: capture opa=req_a and opb=(req_sub ? ~req_b : req_b).
  - Set carry=(req_sub ? 1 : req_cin), idx=0, then go to RUN.
- RUN:
  - add_a=opa[idx*4+:4], add_b=opb[idx*4+:4], add_cin=carry.
  - Each edge: res[idx*4+:4]<=add_sum, carry<=add_cout, idx<=idx+1.
  - When idx==NIB-1, go to DONE instead of incrementing.
- DONE:
  - rsp_valid=1; rsp_sum=res, rsp_cout=carry.
  - rsp_ovf=(opa[MSB]==opb[MSB]) && (res[MSB]!=opa[MSB]).
  - On rsp_ready, go to IDLE.
- add_a, add_b and add_cin are 0 in every state except RUN.
- Latency: request handshake at edge E; rsp_valid is high from edge E+NIB (4 cycles for DATA_W=16). Throughput is one operation per NIB+2 cycles minimum; there is no overlap of DONE and accept.
- Backpressure: rsp_sum, rsp_cout and rsp_ovf stay stable while rsp_valid=1 and rsp_ready=0. req_ready stays 0 and req_valid is ignored.
- req_valid asserted outside IDLE has no effect. The requester must hold the request until req_ready.
- Reset asserted mid-RUN or in DONE discards the operation immediately. No partial response is produced.
- idx width is $clog2(NIB), minimum 1 bit. For NIB=1, RUN lasts exactly one cycle.

Decomposition:
- Shared package add_seq_ctrl_pkg holds:
  - NIB_W=4;
  - typedef enum logic [1:0] {IDLE, RUN, DONE} add_seq_state_t;
  - a function computing signed overflow from the MSBs.
- No sub-module is required. The nibble mux/demux is inline indexed part-selects.
- The bench models the 4-bit adder combinationally and connects it through the existing adder-output interface (cout, sum).

Test Plan:
1. DATA_W=16: A=0x1234, B=0x4321, add, cin=0 -> add_a sequence 4,3,2,1; rsp_sum=0x5555, cout=0, ovf=0; rsp_valid exactly 4 edges after the handshake.
2. A=0xFFFF, B=0x0001, add, cin=0 -> add_cin sequence 0,1,1,1; rsp_sum=0x0000, cout=1, ovf=0.
3. A=0x7FFF, B=0x0001, add -> 0x8000, cout=0, ovf=1. Then sub with A=0x8000, B=0x0001 -> 0x7FFF, cout=1, ovf=1.
4. Sub with A=0x0005, B=0x0007 -> 0xFFFE, cout=0 (borrow), ovf=0. Also verify req_cin=1 is ignored for this subtract.
5. Hold rsp_ready=0 for 5 cycles with req_valid=1 -> rsp fields stable, req_ready=0, no second capture. After rsp_ready, IDLE is reached and the next op is accepted one cycle later.
6. Assert reset while in RUN with idx=2 -> all outputs go to reset values without waiting for a clock edge, and no rsp_valid pulse appears. After release, op 0x0001+0x0001 -> 0x0002.
